// File: rtl/iq_word_packer.sv
// Packs 24-bit IQ pairs into a dense little-endian 32-bit word stream, four pairs per three words.
// Residual bytes are flushed as a partial word with byte enables on enable drop or idle timeout.
module iq_word_packer #(
  parameter int IQ_PAIR_WIDTH = 24,
  parameter int FT_DATA_WIDTH = 32,
  parameter int BUF_BYTES     = 10,
  parameter int FLUSH_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [IQ_PAIR_WIDTH-1:0]   fifo_q,
  input  logic                       fifo_empty,
  output logic                       fifo_rd,
  output logic [FT_DATA_WIDTH-1:0]   out_data,
  output logic [FT_DATA_WIDTH/8-1:0] out_be,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_words
);

  localparam int PB    = IQ_PAIR_WIDTH / 8;
  localparam int WB    = FT_DATA_WIDTH / 8;
  localparam int BUF_W = BUF_BYTES * 8;
  localparam int FW    = $clog2(BUF_BYTES + 1);
  localparam int IW    = $clog2(FLUSH_CYCLES + 1);
  localparam int SW    = $clog2(BUF_W + 1);

  function automatic logic [WB-1:0] be_mask(input logic [FW-1:0] n);
    logic [WB-1:0] m;
    for (int i = 0; i < WB; i++) m[i] = (FW'(i) < n);
    return m;
  endfunction

  logic [BUF_W-1:0] r_buf;
  logic [FW-1:0]    r_f;
  logic             r_rd_d1;
  logic             r_flush;
  logic [IW-1:0]    r_idle;
  logic [15:0]      r_words;

  logic             w_valid;
  logic             w_fire;
  logic [FW-1:0]    w_consume;
  logic [FW-1:0]    w_f_base;
  logic [FW-1:0]    w_f_next;
  logic [SW-1:0]    w_sh_out;
  logic [SW-1:0]    w_sh_in;
  logic [BUF_W-1:0] w_keep;
  logic [BUF_W-1:0] w_ins;
  logic             w_idle_trig;
  logic             w_flush_set;
  logic             w_rd;
  logic [WB-1:0]    w_be;
  logic [FT_DATA_WIDTH-1:0] w_data;

  assign w_valid   = (r_f >= FW'(WB)) | r_flush;
  assign w_fire    = w_valid & out_ready;
  assign w_consume = !w_fire ? '0 : (r_flush ? r_f : FW'(WB));
  assign w_f_base  = r_f - w_consume;
  assign w_f_next  = w_f_base + (r_rd_d1 ? FW'(PB) : '0);

  // Read only if the pair already in flight plus this one still fit.
  assign w_rd = enable & !fifo_empty & !r_flush & !reset &
                (w_f_next <= FW'(BUF_BYTES - PB));

  // Drop the consumed bytes, clear stale bytes above the fill, append the capture.
  assign w_sh_out = SW'(w_consume) << 3;
  assign w_sh_in  = SW'(w_f_base) << 3;
  assign w_keep   = (r_buf >> w_sh_out) & ~({BUF_W{1'b1}} << w_sh_in);
  assign w_ins    = r_rd_d1 ? (BUF_W'(fifo_q) << w_sh_in) : '0;

  assign w_idle_trig = (r_idle >= IW'(FLUSH_CYCLES)) & fifo_empty;
  assign w_flush_set = !r_flush & !r_rd_d1 & (w_f_next != '0) &
                       (w_f_next < FW'(WB)) & (!enable | w_idle_trig);

  always_ff @(posedge clk) begin
    r_buf <= w_keep | w_ins;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_f     <= '0;
      r_rd_d1 <= 1'b0;
      r_flush <= 1'b0;
      r_idle  <= '0;
      r_words <= '0;
    end else begin
      r_f     <= w_f_next;
      r_rd_d1 <= w_rd;
      r_flush <= r_flush ? !w_fire : w_flush_set;
      if (w_fire) r_words <= r_words + 16'd1;
      if (r_rd_d1 | w_fire | (r_f == '0))
        r_idle <= '0;
      else if (fifo_empty & (r_f < FW'(WB)) & (r_idle < IW'(FLUSH_CYCLES)))
        r_idle <= r_idle + IW'(1);
    end
  end

  always_comb begin
    w_be = '0;
    if (w_valid) w_be = r_flush ? be_mask(r_f) : '1;
    w_data = '0;
    for (int i = 0; i < WB; i++)
      if (w_be[i]) w_data[8*i +: 8] = r_buf[8*i +: 8];
  end

  assign fifo_rd   = w_rd;
  assign out_valid = w_valid;
  assign out_be    = w_be;
  assign out_data  = w_data;
  assign out_words = r_words;

endmodule

// File: tb/tb_iq_word_packer.sv
// Randomized bench for iq_word_packer: a byte-queue model of the accumulator predicts every
// presented word, plus directed packing, flush, reset and throughput scenarios.
module tb_iq_word_packer;

  logic        clk = 1'b0;
  logic        reset, enable, fifo_empty, fifo_rd, out_valid, out_ready;
  logic [23:0] fifo_q;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic [15:0] out_words;

  always #5 clk = ~clk;

  iq_word_packer dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_q(fifo_q),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .out_data(out_data),
    .out_be(out_be), .out_valid(out_valid), .out_ready(out_ready),
    .out_words(out_words)
  );

  int ncmp = 0;
  int nerr = 0;

  logic [7:0]  bq[$];
  logic [23:0] pq[$];
  logic [31:0] wlog[$];
  logic [3:0]  belog[$];
  logic [23:0] cap_pair;
  bit          cap_pend = 0;
  int          nfire = 0, rdcnt = 0, cyc = 0, idle_wait = 0, rd2_cyc = -1, v1_cyc = -1;
  bit          rand_ready = 0, thru = 0;
  bit          s_rd, s_fire;
  logic [31:0] s_data;
  logic [3:0]  s_be;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++)
      if (i < n && i < bq.size()) w[8*i +: 8] = bq[i];
    return w;
  endfunction

  task automatic load(input logic [23:0] p);
    pq.push_back(p);
    fifo_empty = 1'b0;
  endtask

  // Sample mid-cycle and check against the model, then advance one edge and update the model.
  task automatic cycle();
    int n, m;
    #1;
    s_rd   = fifo_rd;
    s_fire = out_valid & out_ready;
    s_data = out_data;
    s_be   = out_be;
    n      = bq.size();
    if (reset) begin
      chk("rst_rd", 32'(fifo_rd), 32'd0);
    end else begin
      chk("f_bound", 32'(n <= 10), 32'd1);
      if (n >= 4) begin
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_be", 32'(out_be), 32'hF);
        chk("full_data", out_data, exp_word(4));
      end else if (n == 0) begin
        chk("empty_valid", 32'(out_valid), 32'd0);
      end else if (out_valid) begin
        chk("flush_be", 32'(out_be), (32'd1 << n) - 32'd1);
        chk("flush_data", out_data, exp_word(n));
      end else begin
        idle_wait++;
      end
      if (!enable) chk("rd_off", 32'(fifo_rd), 32'd0);
      if (thru && !fifo_empty) chk("rd_cont", 32'(fifo_rd), 32'd1);
      chk("words", 32'(out_words), 32'(16'(nfire)));
      if (out_valid && v1_cyc < 0) v1_cyc = cyc;
      if (fifo_rd) begin
        rdcnt++;
        if (rdcnt == 2) rd2_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      bq.delete(); wlog.delete(); belog.delete();
      cap_pend = 0;
      nfire = 0;
    end else begin
      if (s_fire) begin
        m = (n < 4) ? n : 4;
        repeat (m) void'(bq.pop_front());
        wlog.push_back(s_data);
        belog.push_back(s_be);
        nfire++;
      end
      if (cap_pend) begin
        bq.push_back(cap_pair[7:0]);
        bq.push_back(cap_pair[15:8]);
        bq.push_back(cap_pair[23:16]);
      end
      cap_pend = s_rd;
      if (s_rd) begin
        if (pq.size() > 0) cap_pair = pq.pop_front();
        else begin
          chk("rd_when_empty", 32'd1, 32'd0);
          cap_pend = 0;
        end
      end
    end
    fifo_q     = cap_pend ? cap_pair : 24'($urandom);
    fifo_empty = (pq.size() == 0);
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    cyc++;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rand_ready = 0;
    thru = 0;
    pq.delete();
    fifo_empty = 1'b1;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    rdcnt = 0; idle_wait = 0; v1_cyc = -1; rd2_cyc = -1;
  endtask

  task automatic post_reset_chk();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_be", 32'(out_be), 32'd0);
    chk("rst_words", 32'(out_words), 32'd0);
  endtask

  task automatic run_until(input int target, input int budget);
    int k;
    k = 0;
    while (nfire < target && k < budget) begin
      cycle();
      k++;
    end
    chk("fire_count", 32'(nfire), 32'(target));
  endtask

  task automatic load_basic();
    load(24'hA1A2A3); load(24'hB1B2B3); load(24'hC1C2C3); load(24'hD1D2D3);
  endtask

  task automatic chk_basic();
    chk("basic_w0", wlog[0], 32'hB3A1A2A3);
    chk("basic_w1", wlog[1], 32'hC2C3B1B2);
    chk("basic_w2", wlog[2], 32'hD1D2D3C1);
    for (int i = 0; i < 3; i++) chk("basic_be", 32'(belog[i]), 32'hF);
  endtask

  initial begin
    logic [23:0] p4;
    int start, k;
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0; fifo_empty = 1'b1; fifo_q = '0;

    // Reset state and basic packing
    do_reset();
    post_reset_chk();
    load_basic();
    enable = 1'b1; out_ready = 1'b1;
    run_until(3, 40);
    repeat (4) cycle();
    chk_basic();
    chk("basic_words", 32'(out_words), 32'd3);
    chk("first_latency", 32'(v1_cyc - rd2_cyc), 32'd2);

    // Backpressure with random out_ready
    do_reset();
    for (int i = 0; i < 400; i++) load(24'(24'h100000 + i));
    enable = 1'b1; rand_ready = 1;
    run_until(300, 4000);
    rand_ready = 0; out_ready = 1'b1;
    repeat (3) cycle();
    chk("bp_words", 32'(out_words), 32'd300);
    chk("bp_left", 32'(bq.size()), 32'd0);

    // Idle flush of a single pair
    do_reset();
    load(24'h123456);
    enable = 1'b1; out_ready = 1'b1;
    run_until(1, 120);
    repeat (3) cycle();
    chk("idle_wait", 32'(idle_wait), 32'd65);
    chk("idle_word", wlog[0], 32'h00123456);
    chk("idle_be", 32'(belog[0]), 32'h7);
    chk("idle_words", 32'(out_words), 32'd1);

    // Enable drop after five reads, with more pairs still queued
    do_reset();
    p4 = '0;
    for (int i = 0; i < 7; i++) begin
      logic [23:0] p;
      p = 24'($urandom);
      if (i == 4) p4 = p;
      load(p);
    end
    enable = 1'b1; out_ready = 1'b1;
    k = 0;
    while (rdcnt < 5 && k < 30) begin cycle(); k++; end
    enable = 1'b0;
    run_until(4, 60);
    repeat (4) cycle();
    for (int i = 0; i < 3; i++) chk("drop_full_be", 32'(belog[i]), 32'hF);
    chk("drop_flush_be", 32'(belog[3]), 32'h7);
    chk("drop_flush_data", wlog[3], {8'h00, p4});
    chk("drop_pairs_left", 32'(pq.size()), 32'd2);

    // Reset while a 2-byte flush is stalled
    do_reset();
    load(24'($urandom)); load(24'($urandom));
    enable = 1'b1; out_ready = 1'b1;
    run_until(1, 20);
    out_ready = 1'b0; enable = 1'b0;
    repeat (4) cycle();
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_be", 32'(out_be), 32'h3);
    load_basic();
    enable = 1'b1; out_ready = 1'b1; reset = 1'b1;
    cycle();
    reset = 1'b0;
    post_reset_chk();
    run_until(3, 40);
    repeat (3) cycle();
    chk_basic();

    // Sustained throughput
    do_reset();
    for (int i = 0; i < 1200; i++) load(24'($urandom));
    enable = 1'b1; out_ready = 1'b1; thru = 1;
    start = cyc;
    run_until(900, 1300);
    chk("thru_cycles", 32'((cyc - start) <= 1203), 32'd1);
    thru = 0;
    repeat (3) cycle();
    chk("thru_words", 32'(out_words), 32'd900);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
